// File: rtl/pwm_meas_pkg.sv
// Shared types, default parameters and a saturating increment for the
// PWM pair duty measurement block.
package pwm_meas_pkg;

  localparam int CNT_W = 13;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {SYNC, MEAS} meas_state_t;

  localparam cnt_t DEF_PERIOD_NOM = 13'd4096;
  localparam cnt_t DEF_TIMEOUT    = 13'd8191;
  localparam cnt_t DEF_NONOVERLAP = 13'h02C;

  // Increment by one when en is set, holding at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v, input logic en);
    if (en && (v != '1)) return v + 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for one asynchronous PWM phase, plus single-cycle
// rise/fall pulses derived from the synchronized level.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic q_d;

  // Synchronizer chain and one-cycle delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
      q_d  <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
      q_d  <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/pwm_duty_meas.sv
// Receive-side decoder for one H-bridge PWM pair. Measures period, high time
// of each phase and the signed net drive once per PWM1 period, with timeout
// reporting for stuck (0%/100%) drive and sticky overlap detection.
// Optional: define DEADTIME_CHK_EN to build the dead-time checker; otherwise
// deadtime_err is tied low.
//
// state | meaning
// ------+-----------------------------------------------------------
// SYNC  | no PWM1 rising edge seen since reset/timeout; no results
// MEAS  | counting a period that started on a PWM1 rising edge
module pwm_duty_meas
  import pwm_meas_pkg::*;
#(
  parameter cnt_t PERIOD_NOM = DEF_PERIOD_NOM,
  parameter cnt_t TIMEOUT    = DEF_TIMEOUT,
  parameter cnt_t NONOVERLAP = DEF_NONOVERLAP
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    PWM1,
  input  logic                    PWM2,
  input  logic                    clr_err,
  output logic [CNT_W-1:0]        period,
  output logic [CNT_W-1:0]        duty1,
  output logic [CNT_W-1:0]        duty2,
  output logic signed [CNT_W:0]   spd,
  output logic                    vld,
  output logic                    stuck,
  output logic                    overlap_err,
  output logic                    deadtime_err
);

  meas_state_t state;
  cnt_t        per_cnt;
  cnt_t        hi1;
  cnt_t        hi2;
  logic        p1_s, p1_rise, p1_fall;
  logic        p2_s, p2_rise, p2_fall;
  cnt_t        to_d1;
  cnt_t        to_d2;

  function automatic logic signed [CNT_W:0] net_drive(input cnt_t a, input cnt_t b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  pwm_edge_sync u_sync1 (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (PWM1),
    .q    (p1_s),
    .rise (p1_rise),
    .fall (p1_fall)
  );

  pwm_edge_sync u_sync2 (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (PWM2),
    .q    (p2_s),
    .rise (p2_rise),
    .fall (p2_fall)
  );

  // A stuck phase reads as full-scale (high) or zero (low) drive.
  assign to_d1 = p1_s ? PERIOD_NOM : '0;
  assign to_d2 = p2_s ? PERIOD_NOM : '0;

  // FSM, period/high-time counters and result registers. A rise restarts the
  // counters on its own cycle so back-to-back periods tile exactly; a rise
  // takes priority over a coincident timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SYNC;
      per_cnt <= '0;
      hi1     <= '0;
      hi2     <= '0;
      period  <= '0;
      duty1   <= '0;
      duty2   <= '0;
      spd     <= '0;
      vld     <= 1'b0;
      stuck   <= 1'b0;
    end else begin
      vld <= 1'b0;
      if (p1_rise) begin
        if (state == MEAS) begin
          period <= per_cnt;
          duty1  <= hi1;
          duty2  <= hi2;
          spd    <= net_drive(hi1, hi2);
          vld    <= 1'b1;
          stuck  <= 1'b0;
        end
        state   <= MEAS;
        per_cnt <= cnt_t'(1);
        hi1     <= cnt_t'(1);
        hi2     <= cnt_t'(p2_s);
      end else if (per_cnt == TIMEOUT) begin
        period  <= '0;
        duty1   <= to_d1;
        duty2   <= to_d2;
        spd     <= net_drive(to_d1, to_d2);
        vld     <= 1'b1;
        stuck   <= 1'b1;
        state   <= SYNC;
        per_cnt <= '0;
        hi1     <= '0;
        hi2     <= '0;
      end else begin
        per_cnt <= sat_inc(per_cnt, 1'b1);
        if (state == MEAS) begin
          hi1 <= sat_inc(hi1, p1_s);
          hi2 <= sat_inc(hi2, p2_s);
        end
      end
    end
  end

  // Sticky overlap flag; a new overlap beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overlap_err <= 1'b0;
    end else if (p1_s & p2_s) begin
      overlap_err <= 1'b1;
    end else if (clr_err) begin
      overlap_err <= 1'b0;
    end
  end

`ifdef DEADTIME_CHK_EN
  cnt_t dead_cnt;
  logic dead_arm;
  logic both_low;
  logic any_fall;
  logic any_rise;
  logic dt_hit;

  assign both_low = ~p1_s & ~p2_s;
  assign any_fall = p1_fall | p2_fall;
  assign any_rise = p1_rise | p2_rise;
  // Only a rise preceded by a fall in MEAS has a measured dead gap behind it.
  assign dt_hit   = any_rise & dead_arm & (state == MEAS) & (dead_cnt < NONOVERLAP);

  // Dead-gap counter and the arm bit that says it holds a valid gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_cnt <= '0;
      dead_arm <= 1'b0;
    end else begin
      if (any_fall) begin
        dead_cnt <= cnt_t'(both_low);
      end else if (both_low) begin
        dead_cnt <= sat_inc(dead_cnt, 1'b1);
      end
      if (state == SYNC) begin
        dead_arm <= 1'b0;
      end else if (any_fall) begin
        dead_arm <= 1'b1;
      end else if (any_rise) begin
        dead_arm <= 1'b0;
      end
    end
  end

  // Sticky short-dead-time flag; a new violation beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deadtime_err <= 1'b0;
    end else if (dt_hit) begin
      deadtime_err <= 1'b1;
    end else if (clr_err) begin
      deadtime_err <= 1'b0;
    end
  end
`else
  // Edge pulses and the dead-time limit have no consumer in this build.
  logic unused_edges;
  localparam cnt_t unused_nonoverlap = NONOVERLAP;
  assign unused_edges = p1_fall ^ p2_fall ^ p2_rise;
  assign deadtime_err = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_duty_meas.sv
// Directed bench for pwm_duty_meas: nominal and swapped duty, stuck-high
// timeout and recovery, overlap flag with clear, dead-time limit, and reset
// in the middle of a period.
module tb_pwm_duty_meas;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               PWM1;
  logic               PWM2;
  logic               clr_err;
  logic [12:0]        period;
  logic [12:0]        duty1;
  logic [12:0]        duty2;
  logic signed [13:0] spd;
  logic               vld;
  logic               stuck;
  logic               overlap_err;
  logic               deadtime_err;

`ifdef DEADTIME_CHK_EN
  localparam int EXP_DT = 1;
`else
  localparam int EXP_DT = 0;
`endif

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int vld_cnt  = 0;
  int last_vld = 0;
  int gap      = 0;
  int base;

  pwm_duty_meas dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PWM1        (PWM1),
    .PWM2        (PWM2),
    .clr_err     (clr_err),
    .period      (period),
    .duty1       (duty1),
    .duty2       (duty2),
    .spd         (spd),
    .vld         (vld),
    .stuck       (stuck),
    .overlap_err (overlap_err),
    .deadtime_err(deadtime_err)
  );

  always #5 clk = ~clk;

  // Count vld pulses and the spacing between them, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (vld === 1'b1) begin
      vld_cnt++;
      gap      = cyc - last_vld;
      last_vld = cyc;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got time-out expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic a, input logic b, input int n);
    PWM1 = a;
    PWM2 = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic per(input int h1, input int d1, input int h2, input int d2);
    drive(1'b1, 1'b0, h1);
    drive(1'b0, 1'b0, d1);
    drive(1'b0, 1'b1, h2);
    drive(1'b0, 1'b0, d2);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    PWM1    = 1'b0;
    PWM2    = 1'b0;
    clr_err = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_period", period, 0);
    chk("rst_duty1", duty1, 0);
    chk("rst_duty2", duty2, 0);
    chk("rst_spd", spd, 0);
    chk("rst_vld", vld, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_overlap", overlap_err, 0);
    chk("rst_deadtime", deadtime_err, 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 10);

    // nominal drive: 3000 / 44 / 1008 / 44
    for (int i = 0; i < 3; i++) per(3000, 44, 1008, 44);
    drive(1'b1, 1'b0, 10);
    chk("t1_vld_cnt", vld_cnt, 3);
    chk("t1_gap", gap, 4096);
    chk("t1_period", period, 4096);
    chk("t1_duty1", duty1, 3000);
    chk("t1_duty2", duty2, 1008);
    chk("t1_spd", spd, 1992);
    chk("t1_stuck", stuck, 0);
    chk("t1_overlap", overlap_err, 0);
    chk("t1_deadtime", deadtime_err, 0);

    // swapped drive; first measured period also holds the 10 lead-in clocks
    base = vld_cnt;
    for (int i = 0; i < 2; i++) per(1008, 44, 3000, 44);
    drive(1'b1, 1'b0, 10);
    chk("t2_vld_cnt", vld_cnt - base, 2);
    chk("t2_period", period, 4096);
    chk("t2_duty1", duty1, 1008);
    chk("t2_duty2", duty2, 3000);
    chk("t2_spd", spd, -1992);
    chk("t2_spd_raw", {18'b0, spd}, 14392);
    chk("t2_overlap", overlap_err, 0);
    chk("t2_deadtime", deadtime_err, 0);

    // PWM1 stuck high -> timeout TIMEOUT clocks after the last measurement
    base = vld_cnt;
    drive(1'b1, 1'b0, 8300);
    chk("t3_vld_cnt", vld_cnt - base, 1);
    chk("t3_gap", gap, 8191);
    chk("t3_stuck", stuck, 1);
    chk("t3_period", period, 0);
    chk("t3_duty1", duty1, 4096);
    chk("t3_duty2", duty2, 0);
    chk("t3_spd", spd, 4096);
    base = vld_cnt;
    drive(1'b0, 1'b0, 44);
    for (int i = 0; i < 2; i++) per(3000, 44, 1008, 44);
    drive(1'b1, 1'b0, 10);
    chk("t3r_vld_cnt", vld_cnt - base, 2);
    chk("t3r_stuck", stuck, 0);
    chk("t3r_period", period, 4096);
    chk("t3r_duty1", duty1, 3000);

    // 5-clock overlap, sticky, then clear; overlap beats clear
    drive(1'b1, 1'b0, 2990);
    drive(1'b1, 1'b1, 5);
    drive(1'b0, 1'b1, 1003);
    drive(1'b0, 1'b0, 88);
    chk("t4_overlap_set", overlap_err, 1);
    drive(1'b0, 1'b0, 20);
    chk("t4_overlap_sticky", overlap_err, 1);
    pulse_clr();
    chk("t4_overlap_clr", overlap_err, 0);
    clr_err = 1'b1;
    drive(1'b1, 1'b1, 6);
    chk("t4_set_wins", overlap_err, 1);
    drive(1'b1, 1'b0, 4);
    clr_err = 1'b0;
    chk("t4_clr_held", overlap_err, 0);
    drive(1'b1, 1'b0, 2990);
    drive(1'b0, 1'b0, 44);
    drive(1'b0, 1'b1, 1008);
    drive(1'b0, 1'b0, 44);
    chk("t4_deadtime", deadtime_err, 0);

    // dead time 20, 43 (just short) and 44 (exactly the limit)
    drive(1'b1, 1'b0, 3000);
    drive(1'b0, 1'b0, 20);
    drive(1'b0, 1'b1, 1008);
    drive(1'b0, 1'b0, 34);
    chk("t5_dead20", deadtime_err, EXP_DT);
    pulse_clr();
    chk("t5_dead20_clr", deadtime_err, 0);
    drive(1'b0, 1'b0, 33);
    drive(1'b1, 1'b0, 3000);
    drive(1'b0, 1'b0, 43);
    drive(1'b0, 1'b1, 1008);
    drive(1'b0, 1'b0, 45);
    chk("t5_dead43", deadtime_err, EXP_DT);
    pulse_clr();
    per(3000, 44, 1008, 43);
    chk("t5_dead44", deadtime_err, 0);
    chk("t5_overlap", overlap_err, 0);

    // reset in the middle of a period
    drive(1'b1, 1'b0, 1500);
    rst_n = 1'b0;
    PWM1  = 1'b0;
    #1;
    chk("t6_period", period, 0);
    chk("t6_duty1", duty1, 0);
    chk("t6_duty2", duty2, 0);
    chk("t6_spd", spd, 0);
    chk("t6_vld", vld, 0);
    chk("t6_stuck", stuck, 0);
    drive(1'b0, 1'b0, 5);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 10);
    base = vld_cnt;
    per(3000, 44, 1008, 44);
    chk("t6_no_vld_first", vld_cnt - base, 0);
    drive(1'b1, 1'b0, 10);
    chk("t6_vld_second", vld_cnt - base, 1);
    chk("t6r_period", period, 4096);
    chk("t6r_duty1", duty1, 3000);
    chk("t6r_duty2", duty2, 1008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
